// File: rtl/cpu_dma_engine_if.sv
// cpu_dma_engine_if: shared data-memory port plus bus request/grant handshake
interface cpu_dma_engine_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  modport master (output bus_req, MemRd, MemWr, Addr, WriteData, input bus_gnt, ReadData);
  modport slave (input bus_req, MemRd, MemWr, Addr, WriteData, output bus_gnt, ReadData);
endinterface

// File: rtl/cpu_dma_engine.sv
// cpu_dma_engine: block copy/fill bus initiator sharing the data-memory port via req/gnt
module cpu_dma_engine #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  cpu_dma_engine_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, DONE} state_t;
  state_t           state_q, state_d;
  logic             mode_q, mode_d, err_q, err_d, rd, wr;
  logic [31:0]      src_q, src_d, dst_q, dst_d, buf_q, buf_d, fill_q, fill_d, addr, wdata;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        src_d  = src_addr;
        dst_d  = dst_addr;
        cnt_d  = len;
        fill_d = fill_data;
        if (dst_addr[1:0] != 2'b0 || (!mode && src_addr[1:0] != 2'b0)) err_d = 1'b1;
        else state_d = (len == '0) ? DONE : REQ;
      end
      REQ: if (bus.bus_gnt) state_d = mode_q ? WRITE : READ;
      READ: if (bus.bus_gnt) begin
        rd      = 1'b1;
        addr    = src_q;
        buf_d   = bus.ReadData;
        state_d = WRITE;
      end
      WRITE: if (bus.bus_gnt) begin
        wr      = 1'b1;
        addr    = dst_q;
        wdata   = mode_q ? fill_q : buf_q;
        dst_d   = dst_q + 32'd4;
        src_d   = mode_q ? src_q : src_q + 32'd4;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == LEN_W'(1)) ? DONE : (mode_q ? WRITE : READ);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.bus_req   = state_q == REQ || state_q == READ || state_q == WRITE;
  assign bus.MemRd     = rd;
  assign bus.MemWr     = wr;
  assign bus.Addr      = addr;
  assign bus.WriteData = wdata;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign err           = err_q;
endmodule
